// File: rtl/spi_clkdiv.sv
// Half-period tick generator for the DAC serial clock.
// Counts clk cycles while enabled and pulses tick on every CLK_DIV-th cycle.
module spi_clkdiv #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || count == DIV_LAST) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign tick = en && (count == DIV_LAST);

endmodule

// File: rtl/dacspi.sv
// Mode-0 SPI transmitter for a DAC, fed from a fifo-style valid/ack source.
// One frame per accepted word: MSB-first shift, a CLK_DIV hold, then a CS_GAP idle gap.
module dacspi #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 1,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ack,
  output logic                  busy,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [7:0]      GAP_LAST = 8'(CS_GAP - 1);

  state_t                  st, st_nx;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nx, shifted;
  logic [BW-1:0]           bitcnt, bitcnt_nx;
  logic [7:0]              gapcnt, gapcnt_nx;
  logic                    cs_n_nx, sclk_nx, mosi_nx, busy_nx, ack_nx;
  logic                    tick;

  spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (st == SHIFT || st == HOLD),
    .tick  (tick)
  );

  assign shifted   = shreg << 1;
  assign fsm_state = st;

  // Handshake: a word is taken on any IDLE edge with valid high; ack pulses for
  // exactly the following cycle so it can drive a fifo read strobe directly.
  always_comb begin
    st_nx     = st;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    cs_n_nx   = cs_n;
    sclk_nx   = sclk;
    mosi_nx   = mosi;
    busy_nx   = busy;
    ack_nx    = 1'b0;
    case (st)
      IDLE: begin
        if (valid) begin
          st_nx     = SHIFT;
          shreg_nx  = data;
          mosi_nx   = data[DATA_WIDTH-1];
          bitcnt_nx = BIT_LAST;
          cs_n_nx   = 1'b0;
          busy_nx   = 1'b1;
          ack_nx    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else begin
            // Falling sclk ends a bit; the last bit leaves SHIFT instead of wrapping.
            sclk_nx = 1'b0;
            if (bitcnt == '0) begin
              mosi_nx = 1'b0;
              st_nx   = HOLD;
            end else begin
              shreg_nx  = shifted;
              mosi_nx   = shifted[DATA_WIDTH-1];
              bitcnt_nx = bitcnt - 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_nx   = 1'b1;
          gapcnt_nx = GAP_LAST;
          st_nx     = GAP;
        end
      end
      GAP: begin
        if (gapcnt == '0) begin
          busy_nx = 1'b0;
          st_nx   = IDLE;
        end else begin
          gapcnt_nx = gapcnt - 8'd1;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      cs_n   <= 1'b1;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      busy   <= 1'b0;
      ack    <= 1'b0;
    end else begin
      st     <= st_nx;
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      gapcnt <= gapcnt_nx;
      cs_n   <= cs_n_nx;
      sclk   <= sclk_nx;
      mosi   <= mosi_nx;
      busy   <= busy_nx;
      ack    <= ack_nx;
    end
  end

endmodule

// File: tb/tb_dacspi.sv
// Bench for dacspi: one instance at CLK_DIV=1 and one at CLK_DIV=3, both CS_GAP=2.
// Bus monitors rebuild each frame from the pins; tasks compare against exp queues.
module tb_dacspi;

  localparam int W   = 16;
  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] data0, data3;
  logic         valid0, valid3;
  logic         ack0, busy0, cs_n0, sclk0, mosi0;
  logic         ack3, busy3, cs_n3, sclk3, mosi3;
  logic [1:0]   st0, st3;

  dacspi #(.DATA_WIDTH(W), .CLK_DIV(1), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .data(data0), .valid(valid0), .ack(ack0), .busy(busy0),
    .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .fsm_state(st0)
  );

  dacspi #(.DATA_WIDTH(W), .CLK_DIV(3), .CS_GAP(GAP)) dut3 (
    .clk(clk), .rst_n(rst_n), .data(data3), .valid(valid3), .ack(ack3), .busy(busy3),
    .cs_n(cs_n3), .sclk(sclk3), .mosi(mosi3), .fsm_state(st3)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q0[$], exp_q3[$];
  logic [W-1:0] got_q0[$], got_q3[$];
  int len_q0[$], rise_q0[$], hi_q0[$], ack_cyc_q0[$];
  int len_q3[$], rise_q3[$];
  int cyc = 0;
  int ack_cnt0 = 0, ack_cnt3 = 0, mosi_viol = 0, run_bad3 = 0;

  // ---------------- monitor, CLK_DIV=1 instance ----------------
  logic         prev_cs0, prev_sclk0, prev_mosi0, in_frame0, seen_frame0;
  int           low_len0, rises0, high_len0;
  logic [W-1:0] word0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_cs0 = 1'b1; prev_sclk0 = 1'b0; prev_mosi0 = 1'b0;
      in_frame0 = 1'b0; seen_frame0 = 1'b0;
      low_len0 = 0; rises0 = 0; high_len0 = 0; word0 = '0;
    end else begin
      if (ack0) begin
        ack_cnt0++;
        ack_cyc_q0.push_back(cyc);
      end
      if (prev_cs0 && !cs_n0) begin
        if (seen_frame0) hi_q0.push_back(high_len0);
        in_frame0 = 1'b1; low_len0 = 0; rises0 = 0; word0 = '0;
      end
      if (in_frame0 && !prev_cs0 && cs_n0) begin
        got_q0.push_back(word0);
        len_q0.push_back(low_len0);
        rise_q0.push_back(rises0);
        in_frame0 = 1'b0; seen_frame0 = 1'b1; high_len0 = 0;
      end
      if (!cs_n0) low_len0++;
      else        high_len0++;
      if (in_frame0 && !prev_sclk0 && sclk0) begin
        rises0++;
        word0 = {word0[W-2:0], mosi0};
      end
      if (sclk0 && mosi0 !== prev_mosi0) mosi_viol++;
      prev_cs0 = cs_n0; prev_sclk0 = sclk0; prev_mosi0 = mosi0;
    end
  end

  // ---------------- monitor, CLK_DIV=3 instance ----------------
  logic         prev_cs3, prev_sclk3, prev_mosi3, in_frame3;
  int           low_len3, rises3, run3;
  logic [W-1:0] word3;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs3 = 1'b1; prev_sclk3 = 1'b0; prev_mosi3 = 1'b0; in_frame3 = 1'b0;
      low_len3 = 0; rises3 = 0; run3 = 0; word3 = '0;
    end else begin
      if (ack3) ack_cnt3++;
      if (prev_cs3 && !cs_n3) begin
        in_frame3 = 1'b1; low_len3 = 0; rises3 = 0; run3 = 0; word3 = '0;
      end
      if (in_frame3 && !prev_cs3 && cs_n3) begin
        if (run3 != 3) run_bad3++;
        got_q3.push_back(word3);
        len_q3.push_back(low_len3);
        rise_q3.push_back(rises3);
        in_frame3 = 1'b0;
      end
      if (in_frame3) begin
        low_len3++;
        // Every sclk phase, including the lead-in and the hold, lasts 3 cycles.
        if (sclk3 != prev_sclk3) begin
          if (run3 != 3) run_bad3++;
          run3 = 1;
        end else begin
          run3++;
        end
        if (!prev_sclk3 && sclk3) begin
          rises3++;
          word3 = {word3[W-2:0], mosi3};
        end
      end
      if (sclk3 && mosi3 !== prev_mosi3) mosi_viol++;
      prev_cs3 = cs_n3; prev_sclk3 = sclk3; prev_mosi3 = mosi3;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_frames(input int which, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if ((which == 0 ? got_q0.size() : got_q3.size()) >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send0(input logic [W-1:0] word);
    @(posedge clk); #1;
    data0 = word; valid0 = 1'b1;
    exp_q0.push_back(word);
    @(posedge clk); #1;
    valid0 = 1'b0; data0 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0; data0 = '0; data3 = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cs_n0, sclk0, mosi0, ack0, busy0} !== 5'b10000) begin
      bad++; $display("FAIL reset_pins0 got=%b need=10000", {cs_n0, sclk0, mosi0, ack0, busy0});
    end
    total++;
    if (st0 !== 2'd0) begin bad++; $display("FAIL reset_state0 got=%0d need=0", st0); end
    total++;
    if ({cs_n3, sclk3, mosi3, ack3, busy3} !== 5'b10000) begin
      bad++; $display("FAIL reset_pins3 got=%b need=10000", {cs_n3, sclk3, mosi3, ack3, busy3});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({cs_n0, sclk0, busy0, ack0} !== 4'b1000) begin
      bad++; $display("FAIL idle_hold got=%b need=1000", {cs_n0, sclk0, busy0, ack0});
    end
  endtask

  task automatic test_single();
    int acks; bit ok; logic [W-1:0] got, exp;
    acks = ack_cnt0;
    @(posedge clk); #1;
    data0 = 16'hA5C3; valid0 = 1'b1;
    exp_q0.push_back(16'hA5C3);
    @(posedge clk); #1;
    valid0 = 1'b0; data0 = '0;
    total++;
    if ({ack0, busy0, cs_n0} !== 3'b110) begin
      bad++; $display("FAIL accept_outputs got=%b need=110", {ack0, busy0, cs_n0});
    end
    @(posedge clk); #1;
    total++;
    if (ack0 !== 1'b0) begin bad++; $display("FAIL ack_width got=%b need=0", ack0); end
    wait_frames(0, 1, 100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_timeout frames=%0d need=1", got_q0.size());
    end else begin
      got = got_q0.pop_front(); exp = exp_q0.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL single_word got=%h need=%h", got, exp); end
      total++;
      if (len_q0[0] != 33) begin bad++; $display("FAIL single_cs_low got=%0d need=33", len_q0[0]); end
      total++;
      if (rise_q0[0] != 16) begin bad++; $display("FAIL single_rises got=%0d need=16", rise_q0[0]); end
    end
    len_q0.delete(); rise_q0.delete();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b need=0", busy0); end
    total++;
    if (ack_cnt0 - acks != 1) begin
      bad++; $display("FAIL single_acks got=%0d need=1", ack_cnt0 - acks);
    end
  endtask

  task automatic test_clkdiv3();
    int bad_runs, acks; bit ok; logic [W-1:0] got, exp;
    bad_runs = run_bad3; acks = ack_cnt3;
    @(posedge clk); #1;
    data3 = 16'h8001; valid3 = 1'b1;
    exp_q3.push_back(16'h8001);
    @(posedge clk); #1;
    valid3 = 1'b0; data3 = '0;
    wait_frames(3, 1, 300, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL div3_timeout frames=%0d need=1", got_q3.size());
    end else begin
      got = got_q3.pop_front(); exp = exp_q3.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL div3_word got=%h need=%h", got, exp); end
      total++;
      if (len_q3[0] != 99) begin bad++; $display("FAIL div3_cs_low got=%0d need=99", len_q3[0]); end
      total++;
      if (rise_q3[0] != 16) begin bad++; $display("FAIL div3_rises got=%0d need=16", rise_q3[0]); end
    end
    len_q3.delete(); rise_q3.delete();
    total++;
    if (run_bad3 != bad_runs) begin
      bad++; $display("FAIL div3_phase_len bad_phases=%0d need=0", run_bad3 - bad_runs);
    end
    total++;
    if (ack_cnt3 - acks != 1) begin bad++; $display("FAIL div3_acks got=%0d need=1", ack_cnt3 - acks); end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fifo[$];
    logic [W-1:0] got, exp, tmp;
    bit ok;
    fifo.push_back(16'h0001); fifo.push_back(16'hFFFF);
    exp_q0.push_back(16'h0001); exp_q0.push_back(16'hFFFF);
    ack_cyc_q0.delete(); hi_q0.delete();
    @(posedge clk); #1;
    data0 = fifo[0]; valid0 = 1'b1;
    for (int i = 0; i < 200 && valid0; i++) begin
      @(posedge clk); #1;
      if (ack0) begin
        tmp = fifo.pop_front();
        if (fifo.size() == 0) begin valid0 = 1'b0; data0 = '0; end
        else data0 = fifo[0];
      end
    end
    wait_frames(0, 2, 200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_timeout frames=%0d need=2", got_q0.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        got = got_q0.pop_front(); exp = exp_q0.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL b2b_word%0d got=%h need=%h", k, got, exp); end
        total++;
        if (len_q0[k] != 33) begin bad++; $display("FAIL b2b_cs_low%0d got=%0d need=33", k, len_q0[k]); end
      end
      total++;
      if (ack_cyc_q0.size() != 2) begin
        bad++; $display("FAIL b2b_ack_count got=%0d need=2", ack_cyc_q0.size());
      end else begin
        total++;
        if (ack_cyc_q0[1] - ack_cyc_q0[0] != 36) begin
          bad++; $display("FAIL b2b_ack_spacing got=%0d need=36", ack_cyc_q0[1] - ack_cyc_q0[0]);
        end
      end
      // cs_n is high through the CS_GAP cycles plus the IDLE accept cycle.
      total++;
      if (hi_q0.size() == 0 || hi_q0[$] != GAP + 1) begin
        bad++; $display("FAIL b2b_cs_high got=%0d need=%0d", hi_q0.size() == 0 ? -1 : hi_q0[$], GAP + 1);
      end
    end
    len_q0.delete(); rise_q0.delete();
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int acks, glitches; bit ok; logic [W-1:0] got, exp;
    acks = ack_cnt0; glitches = 0;
    @(posedge clk); #1;
    data0 = 16'h3E5A; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; data0 = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rises0 >= 7) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_reach7 rises=%0d need=7", rises0); end
    rst_n = 1'b0; #1;
    total++;
    if ({cs_n0, sclk0, mosi0, busy0, ack0} !== 5'b10000) begin
      bad++; $display("FAIL abort_pins got=%b need=10000", {cs_n0, sclk0, mosi0, busy0, ack0});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sclk0 !== 1'b0 || cs_n0 !== 1'b1) glitches++;
    end
    total++;
    if (glitches != 0) begin bad++; $display("FAIL abort_quiet glitches=%0d need=0", glitches); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    total++;
    if (got_q0.size() != 0) begin bad++; $display("FAIL abort_no_frame got=%0d need=0", got_q0.size()); end
    send0(16'h5A3C);
    wait_frames(0, 1, 100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL resume_timeout frames=%0d need=1", got_q0.size());
    end else begin
      got = got_q0.pop_front(); exp = exp_q0.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL resume_word got=%h need=%h", got, exp); end
      total++;
      if (len_q0[0] != 33 || rise_q0[0] != 16) begin
        bad++; $display("FAIL resume_shape got=%0d/%0d need=33/16", len_q0[0], rise_q0[0]);
      end
    end
    len_q0.delete(); rise_q0.delete();
    repeat (40) @(posedge clk);
    total++;
    if (got_q0.size() != 0 || ack_cnt0 - acks != 2) begin
      bad++; $display("FAIL no_retransmit frames=%0d acks=%0d need=0/2", got_q0.size(), ack_cnt0 - acks);
    end
  endtask

  task automatic test_data_toggle();
    int acks; bit ok; logic [W-1:0] got, exp;
    acks = ack_cnt0;
    @(posedge clk); #1;
    data0 = 16'hC3A5; valid0 = 1'b1;
    exp_q0.push_back(16'hC3A5);
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      data0  = W'($urandom);
      valid0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    valid0 = 1'b0; data0 = '0;
    wait_frames(0, 1, 100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL toggle_timeout frames=%0d need=1", got_q0.size());
    end else begin
      got = got_q0.pop_front(); exp = exp_q0.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL toggle_word got=%h need=%h", got, exp); end
    end
    len_q0.delete(); rise_q0.delete();
    repeat (6) @(posedge clk);
    total++;
    if (ack_cnt0 - acks != 1) begin bad++; $display("FAIL toggle_acks got=%0d need=1", ack_cnt0 - acks); end
  endtask

  task automatic test_random();
    bit ok; logic [W-1:0] got, exp;
    for (int n = 0; n < 4; n++) begin
      send0(W'($urandom_range(0, 16'hFFFF)));
      wait_frames(0, 1, 100, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL rand_timeout%0d frames=%0d need=1", n, got_q0.size());
      end else begin
        got = got_q0.pop_front(); exp = exp_q0.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL rand_word%0d got=%h need=%h", n, got, exp); end
      end
      len_q0.delete(); rise_q0.delete();
      repeat (4) @(posedge clk);
    end
    total++;
    if (mosi_viol != 0) begin bad++; $display("FAIL mosi_while_sclk_high got=%0d need=0", mosi_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_clkdiv3();
    test_back_to_back();
    test_reset_mid();
    test_data_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
